// File: rtl/ram_bist_pkg.sv
// Shared types and constants for the RAM built-in self-test.
package ram_bist_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    DRAIN,
    DONE
  } state_t;

  localparam logic [7:0] ERR_CNT_MAX  = 8'd255;
  localparam logic [7:0] DEFAULT_SEED = 8'hA5;

endpackage

// File: rtl/ram_bist_cmp.sv
// Read-back checker: aligns address/expected data with the registered RAM
// output, counts mismatches (saturating) and captures the first failing address.
module ram_bist_cmp #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clr,
  input  logic              i_vld,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_exp,
  input  logic [DATA_W-1:0] i_rdata,
  output logic [7:0]        o_err_cnt,
  output logic [ADDR_W-1:0] o_fail_addr,
  output logic              o_mismatch
);
  import ram_bist_pkg::*;

  logic              r_chk_vld;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_exp;
  logic [7:0]        r_err_cnt;
  logic [ADDR_W-1:0] r_fail_addr;
  logic              w_mismatch;

  assign w_mismatch = r_chk_vld && (i_rdata != r_exp);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_chk_vld   <= 1'b0;
      r_addr      <= '0;
      r_exp       <= '0;
      r_err_cnt   <= '0;
      r_fail_addr <= '0;
    end else begin
      r_chk_vld <= i_vld;
      r_addr    <= i_addr;
      r_exp     <= i_exp;
      if (i_clr) begin
        r_err_cnt   <= '0;
        r_fail_addr <= '0;
      end else if (w_mismatch) begin
        if (r_err_cnt != ERR_CNT_MAX) r_err_cnt <= r_err_cnt + 8'd1;
        if (r_err_cnt == '0) r_fail_addr <= r_addr;
      end
    end
  end

  assign o_err_cnt   = r_err_cnt;
  assign o_fail_addr = r_fail_addr;
  assign o_mismatch  = w_mismatch;

endmodule

// File: rtl/ram_bist.sv
// RAM self-test initiator: writes a seeded address pattern, reads it back and
// reports pass/error count/first failing address. RAM_BIST_INV_PASS_EN adds a
// second pass with the complemented pattern.
module ram_bist
  import ram_bist_pkg::*;
#(
  parameter int unsigned       ADDR_W = 10,
  parameter int unsigned       DATA_W = 8,
  parameter logic [DATA_W-1:0] SEED   = DATA_W'(DEFAULT_SEED)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_pass,
  output logic [7:0]        o_err_cnt,
  output logic [ADDR_W-1:0] o_fail_addr,
  output logic              o_ram_we,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_wdata,
  input  logic [DATA_W-1:0] i_ram_rdata
);

  state_t            r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_inv;
  logic              r_we;
  logic [DATA_W-1:0] r_wdata;
  logic              r_busy;
  logic              r_done;
  logic              r_pass;

  logic [ADDR_W-1:0] w_cnt_inc;
  logic              w_cnt_last;
  logic [DATA_W-1:0] w_inv_mask;
  logic [DATA_W-1:0] w_exp_cur;
  logic [DATA_W-1:0] w_exp_inc;
  logic              w_start_acc;
  logic              w_second_pass;
  logic [7:0]        w_err_cnt;
  logic              w_mismatch;

  assign w_cnt_inc   = r_cnt + ADDR_W'(1);
  assign w_cnt_last  = (r_cnt == '1);
  assign w_inv_mask  = {DATA_W{r_inv}};
  assign w_exp_cur   = DATA_W'(r_cnt) ^ SEED ^ w_inv_mask;
  assign w_exp_inc   = DATA_W'(w_cnt_inc) ^ SEED ^ w_inv_mask;
  assign w_start_acc = (r_state == IDLE) && i_start;

`ifdef RAM_BIST_INV_PASS_EN
  always_ff @(posedge i_clk) begin
    if (i_rst || w_start_acc) r_inv <= 1'b0;
    else if (r_state == DRAIN && !r_inv) r_inv <= 1'b1;
  end
  assign w_second_pass = !r_inv;
`else
  assign r_inv         = 1'b0;
  assign w_second_pass = 1'b0;
`endif

  // Write data is registered one address ahead so it lines up with r_cnt.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_wdata <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (i_start) begin
            r_state <= WRITE;
            r_cnt   <= '0;
            r_we    <= 1'b1;
            r_wdata <= SEED;
            r_busy  <= 1'b1;
            r_pass  <= 1'b0;
          end
        end
        WRITE: begin
          r_cnt   <= w_cnt_inc;
          r_wdata <= w_exp_inc;
          if (w_cnt_last) begin
            r_state <= READ;
            r_we    <= 1'b0;
          end
        end
        READ: begin
          r_cnt <= w_cnt_inc;
          if (w_cnt_last) r_state <= DRAIN;
        end
        DRAIN: begin
          if (w_second_pass) begin
            r_state <= WRITE;
            r_we    <= 1'b1;
            r_wdata <= ~SEED;
          end else begin
            r_state <= DONE;
            r_done  <= 1'b1;
            // Include the final-location compare resolving in this cycle.
            r_pass  <= (w_err_cnt == '0) && !w_mismatch;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  ram_bist_cmp #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_cmp (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_clr      (w_start_acc),
    .i_vld      (r_state == READ),
    .i_addr     (r_cnt),
    .i_exp      (w_exp_cur),
    .i_rdata    (i_ram_rdata),
    .o_err_cnt  (w_err_cnt),
    .o_fail_addr(o_fail_addr),
    .o_mismatch (w_mismatch)
  );

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_pass      = r_pass;
  assign o_err_cnt   = w_err_cnt;
  assign o_ram_we    = r_we;
  assign o_ram_addr  = r_cnt;
  assign o_ram_wdata = r_wdata;

endmodule
